fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Control and data-steering stage directly upstream of the radix-2 butterfly. It runs an in-place decimation-in-time FFT over a 2^LOG2N-point complex buffer, whose input is already loaded in bit-reversed order. For each butterfly it reads an operand pair and its twiddle factor, holds them stable into the butterfly, captures the butterfly results, and writes them back to the same two addresses. It walks every stage and pair, then pulses done.

## Interface
- `LOG2N`, 4: log2 of point count N; N/2 butterflies per stage, LOG2N stages.
- `BF_LATENCY`, 3: cycles from operand presentation to valid butterfly outputs.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_start`  in  1  begin transform; sampled only in IDLE.
- `o_busy`  out  1  high from start acceptance until DONE exits.
- `o_done`  out  1  one-cycle pulse at end of transform.
- `o_rd_en`  out  1  buffer read strobe; data returns next cycle.
- `o_rd_addr_a`, `o_rd_addr_b`  out  LOG2N  operand addresses.
- `i_rd_data_ra`, `i_rd_data_ca`, `i_rd_data_rb`, `i_rd_data_cb`  in  data_size+1  read data for A/B, real/imag.
- `o_tw_addr`  out  LOG2N-1  twiddle ROM index; ROM data returns next cycle.
- `i_tw_r`, `i_tw_c`  in  data_size+1  twiddle real/imag.
- `o_bf_ra`, `o_bf_ca`, `o_bf_rb`, `o_bf_cb`, `o_bf_tw_r`, `o_bf_tw_c`  out  data_size+1  butterfly operands.
- `i_bf_ra`, `i_bf_ca`, `i_bf_rb`, `i_bf_cb`  in  data_size+1  butterfly results.
- `o_wr_en`  out  1  buffer write strobe.
- `o_wr_addr_a`, `o_wr_addr_b`  out  LOG2N  write addresses.
- `o_wr_data_ra`, `o_wr_data_ca`, `o_wr_data_rb`, `o_wr_data_cb`  out  data_size+1  write data.

## Operation
- Data is two's complement, data_size+1 bits, with data_size fractional bits.
- Counters: stage `s` runs 0..LOG2N-1; pair `k` runs 0..N/2-1.
- Address rules:
  - half = 1<<s.
  - addr_a = ((k>>s) << (s+1)) | (k & (half-1)).
  - addr_b = addr_a + half.
  - tw index = (k & (half-1)) << (LOG2N-1-s).
- FSM states and transitions:
  - IDLE: leave on i_start=1, clear s and k, go to READ.
  - READ: drive o_rd_en=1, the addresses and o_tw_addr for one cycle, go to FETCH.
  - FETCH: register read data and twiddle into the o_bf_* registers, go to COMPUTE.
  - COMPUTE: hold o_bf_* stable for BF_LATENCY cycles, counted by a cycle counter. On the last cycle, capture i_bf_* into the o_wr_data_* registers and go to WRITE.
  - WRITE: drive o_wr_en=1 with addr_a/addr_b for one cycle. Then:
    - if k < N/2-1: k+1, go to READ;
    - else if s < LOG2N-1: s+1, k=0, go to READ;
    - else go to DONE.
  - DONE: o_done=1 for one cycle, then go to IDLE. o_busy falls on entering IDLE.
- Fully sequential: a read never overlaps an outstanding write, so there is no RAW hazard.
- i_start is ignored outside IDLE.
- Reset, including mid-transform, aborts immediately:
  - FSM goes to IDLE; all counters clear.
  - Buffer contents are left as written so far.

## Timing
- Reset value of every output is 0.
- Per butterfly: BF_LATENCY+3 cycles (READ 1, FETCH 1, COMPUTE BF_LATENCY, WRITE 1).
- Start to done: i_start sampled at edge 0. o_done is high during cycle (N/2)·LOG2N·(BF_LATENCY+3)+1. With defaults this is cycle 193 (192 butterfly cycles, then DONE).
- Outputs are registered: o_rd_en, o_wr_en, o_done, o_busy and all addresses change only on clock edges.
- o_wr_data_* stay constant between captures.

## Configuration
- `FFT_SCALE_EN` defined: butterfly results are arithmetically shifted right by 1 (sign-preserving) before writing. This gives a total scale of 1/N and prevents growth overflow.
- `FFT_SCALE_EN` undefined: results are written unchanged; the caller guarantees headroom.

## Structure
- Shared package/header (alongside `parameters.v`) holds:
  - `data_size`;
  - FSM state encodings (IDLE, READ, FETCH, COMPUTE, WRITE, DONE);
  - a `bit_reverse` helper function for benches.
- One natural sub-module: `fft_addr_gen`, a combinational block mapping (s, k) to addr_a, addr_b and tw index.

## Test plan
Unless stated otherwise, tests use LOG2N=4, data_size=15, a behavioural butterfly with BF_LATENCY=3, and a behavioural twiddle ROM with W^j = (cos, −sin) in Q15.
- Address walk: one transform.
  - Stage 0 writes pairs (0,1),(2,3)…(14,15) with tw 0.
  - Stage 3 writes pairs (0,8),(1,9)…(7,15) with tw 0..7.
  - Exactly 32 o_wr_en pulses.
- Impulse: x[0]=0x4000, all others 0.
  - Unscaled: every bin has real 0x4000, imag 0.
  - With FFT_SCALE_EN: every bin has real 0x0400.
- Timing: i_start at edge 0 → o_done high only in cycle 193; o_busy high for cycles 1–193.
- Start while busy: pulse i_start at cycle 50 → ignored; single o_done at cycle 193.
- Reset mid-run: rst_n=0 at cycle 100 → next edge all outputs 0 and state IDLE. A fresh i_start then completes after 192 more cycles.
- DC input: all x=0x0800, with FFT_SCALE_EN → bin 0 = 0x0800, bins 1–15 ≈ 0 (within ±2 LSB).

Source files
------------

// File: rtl/fft_stage_sequencer_pkg.sv
// Shared constants, FSM state encoding and bench helpers for the FFT stage sequencer.
package fft_stage_sequencer_pkg;

  localparam int data_size = 15;
  localparam int DW        = data_size + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_FETCH,
    ST_COMPUTE,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Reverses the low 'bits' bits of v; used to place input samples in DIT order.
  function automatic int unsigned bit_reverse(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int i = 0; i < int'(bits); i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Buffer, twiddle ROM and butterfly bus between the sequencer (master) and the datapath (slave).
interface fft_stage_sequencer_if #(parameter int LOG2N = 4);
  import fft_stage_sequencer_pkg::*;

  logic             o_rd_en;
  logic [LOG2N-1:0] o_rd_addr_a, o_rd_addr_b;
  logic [DW-1:0]    i_rd_data_ra, i_rd_data_ca, i_rd_data_rb, i_rd_data_cb;
  logic [LOG2N-2:0] o_tw_addr;
  logic [DW-1:0]    i_tw_r, i_tw_c;
  logic [DW-1:0]    o_bf_ra, o_bf_ca, o_bf_rb, o_bf_cb, o_bf_tw_r, o_bf_tw_c;
  logic [DW-1:0]    i_bf_ra, i_bf_ca, i_bf_rb, i_bf_cb;
  logic             o_wr_en;
  logic [LOG2N-1:0] o_wr_addr_a, o_wr_addr_b;
  logic [DW-1:0]    o_wr_data_ra, o_wr_data_ca, o_wr_data_rb, o_wr_data_cb;

  modport master (
    output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
    output o_bf_ra, o_bf_ca, o_bf_rb, o_bf_cb, o_bf_tw_r, o_bf_tw_c,
    output o_wr_en, o_wr_addr_a, o_wr_addr_b,
    output o_wr_data_ra, o_wr_data_ca, o_wr_data_rb, o_wr_data_cb,
    input  i_rd_data_ra, i_rd_data_ca, i_rd_data_rb, i_rd_data_cb,
    input  i_tw_r, i_tw_c,
    input  i_bf_ra, i_bf_ca, i_bf_rb, i_bf_cb
  );

  modport slave (
    input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
    input  o_bf_ra, o_bf_ca, o_bf_rb, o_bf_cb, o_bf_tw_r, o_bf_tw_c,
    input  o_wr_en, o_wr_addr_a, o_wr_addr_b,
    input  o_wr_data_ra, o_wr_data_ca, o_wr_data_rb, o_wr_data_cb,
    output i_rd_data_ra, i_rd_data_ca, i_rd_data_rb, i_rd_data_cb,
    output i_tw_r, i_tw_c,
    output i_bf_ra, i_bf_ca, i_bf_rb, i_bf_cb
  );

endinterface

// File: rtl/fft_stage_sequencer_addr_gen.sv
// Maps (stage s, pair k) to the in-place DIT operand addresses and twiddle index.
module fft_addr_gen #(
  parameter  int LOG2N = 4,
  localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic [SW-1:0]    i_s,
  input  logic [LOG2N-2:0] i_k,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [LOG2N-2:0] o_tw_addr
);

  logic [LOG2N-1:0] k_ext, half, low;

  always_comb begin
    k_ext     = {1'b0, i_k};
    half      = LOG2N'(1) << i_s;
    low       = k_ext & (half - LOG2N'(1));
    // Group index goes above the 'half' bit, offset within group stays below it.
    o_addr_a  = (((k_ext >> i_s) << i_s) << 1) | low;
    o_addr_b  = o_addr_a + half;
    o_tw_addr = low[LOG2N-2:0] << (SW'(LOG2N - 1) - i_s);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: read pair, hold for butterfly, write back, per stage/pair.
// Build option FFT_SCALE_EN: butterfly results are halved (arithmetic shift) before write-back.
// state      | meaning
// ST_IDLE    | waiting for i_start
// ST_READ    | read strobe with operand and twiddle addresses
// ST_FETCH   | register read data and twiddle into butterfly operands
// ST_COMPUTE | hold operands BF_LATENCY cycles, capture results on the last
// ST_WRITE   | write strobe, advance pair/stage
// ST_DONE    | one-cycle done pulse
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int LOG2N      = 4,
  parameter int BF_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  fft_stage_sequencer_if.master bus
);

  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int KW = LOG2N - 1;
  localparam int CW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [CW-1:0] C_LOAD = CW'(BF_LATENCY - 1);

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x);
`ifdef FFT_SCALE_EN
    return {x[DW-1], x[DW-1:1]};
`else
    return x;
`endif
  endfunction

  state_e            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [LOG2N-1:0]  rd_a_q, rd_a_d, rd_b_q, rd_b_d, wr_a_q, wr_a_d, wr_b_q, wr_b_d;
  logic [LOG2N-2:0]  tw_q, tw_d;
  logic [5:0][DW-1:0] bf_q, bf_d;
  logic [3:0][DW-1:0] wd_q, wd_d;
  logic [LOG2N-1:0]  gen_a, gen_b;
  logic [LOG2N-2:0]  gen_tw;

  // Addresses are generated from the next (s, k) so they register in step with the strobes.
  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .i_s       (s_d),
    .i_k       (k_d),
    .o_addr_a  (gen_a),
    .o_addr_b  (gen_b),
    .o_tw_addr (gen_tw)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    bf_d    = bf_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          s_d     = '0;
          k_d     = '0;
          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_FETCH;
      ST_FETCH: begin
        bf_d    = {bus.i_tw_c, bus.i_tw_r, bus.i_rd_data_cb, bus.i_rd_data_rb,
                   bus.i_rd_data_ca, bus.i_rd_data_ra};
        cnt_d   = C_LOAD;
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (cnt_q == '0) begin
          wd_d    = {scale(bus.i_bf_cb), scale(bus.i_bf_rb), scale(bus.i_bf_ca), scale(bus.i_bf_ra)};
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WRITE: begin
        if (k_q != {KW{1'b1}}) begin
          k_d     = k_q + KW'(1);
          state_d = ST_READ;
        end else if (s_q != S_LAST) begin
          s_d     = s_q + SW'(1);
          k_d     = '0;
          state_d = ST_READ;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    rd_en_d = (state_d == ST_READ);
    wr_en_d = (state_d == ST_WRITE);
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    tw_d    = tw_q;
    wr_a_d  = wr_a_q;
    wr_b_d  = wr_b_q;
    if (rd_en_d) begin
      rd_a_d = gen_a;
      rd_b_d = gen_b;
      tw_d   = gen_tw;
    end
    if (wr_en_d) begin
      wr_a_d = gen_a;
      wr_b_d = gen_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      wr_a_q  <= '0;
      wr_b_q  <= '0;
      bf_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      wr_a_q  <= wr_a_d;
      wr_b_q  <= wr_b_d;
      bf_q    <= bf_d;
      wd_q    <= wd_d;
    end
  end

  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign bus.o_rd_en      = rd_en_q;
  assign bus.o_rd_addr_a  = rd_a_q;
  assign bus.o_rd_addr_b  = rd_b_q;
  assign bus.o_tw_addr    = tw_q;
  assign bus.o_bf_ra      = bf_q[0];
  assign bus.o_bf_ca      = bf_q[1];
  assign bus.o_bf_rb      = bf_q[2];
  assign bus.o_bf_cb      = bf_q[3];
  assign bus.o_bf_tw_r    = bf_q[4];
  assign bus.o_bf_tw_c    = bf_q[5];
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr_a  = wr_a_q;
  assign bus.o_wr_addr_b  = wr_b_q;
  assign bus.o_wr_data_ra = wd_q[0];
  assign bus.o_wr_data_ca = wd_q[1];
  assign bus.o_wr_data_rb = wd_q[2];
  assign bus.o_wr_data_cb = wd_q[3];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: behavioural buffer, twiddle ROM and butterfly around the DUT,
// checked against an in-place FFT reference model and fixed address/timing expectations.
module tb_fft_stage_sequencer;
  import fft_stage_sequencer_pkg::*;

  localparam int LOG2N      = 4;
  localparam int N          = 1 << LOG2N;
  localparam int BF_LATENCY = 3;
  localparam int N_BF       = (N / 2) * LOG2N;
  localparam int DONE_CYC   = N_BF * (BF_LATENCY + 3) + 1;
  localparam int RUN_CYC    = 240;
  localparam int LOGSZ      = 512;
`ifdef FFT_SCALE_EN
  localparam logic [15:0] IMP_BIN = 16'h0400;
  localparam logic [15:0] DC_AMP  = 16'h0800;
  localparam logic [15:0] DC_BIN0 = 16'h0800;
`else
  localparam logic [15:0] IMP_BIN = 16'h4000;
  localparam logic [15:0] DC_AMP  = 16'h0400;
  localparam logic [15:0] DC_BIN0 = 16'h4000;
`endif

  typedef struct packed { logic [15:0] ra, ca, rb, cb; } bf_t;
  typedef struct { int idx; int a; int b; int tw; } walk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic o_busy, o_done;

  fft_stage_sequencer_if #(.LOG2N(LOG2N)) bus ();

  fft_stage_sequencer #(.LOG2N(LOG2N), .BF_LATENCY(BF_LATENCY)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic signed [15:0] mem_r[N], mem_c[N], ld_r[N], ld_c[N], x_r[N], x_c[N], m_r[N], m_c[N];
  logic signed [15:0] rom_r[N/2], rom_c[N/2];
  logic ld_req = 1'b0;
  bf_t  p1, p2;
  int   wr_cnt, rd_cnt;
  int   wlog[LOGSZ], rlog[LOGSZ];
  int   checks = 0, errors = 0;

  function automatic bf_t bfly(input logic signed [15:0] ar, ai, br, bi, wr, wi);
    longint tr, ti;
    bf_t r;
    tr = (longint'(br) * longint'(wr) - longint'(bi) * longint'(wi) + 16384) >>> 15;
    ti = (longint'(br) * longint'(wi) + longint'(bi) * longint'(wr) + 16384) >>> 15;
    r.ra = 16'(longint'(ar) + tr);
    r.ca = 16'(longint'(ai) + ti);
    r.rb = 16'(longint'(ar) - tr);
    r.cb = 16'(longint'(ai) - ti);
    return r;
  endfunction

  function automatic logic signed [15:0] scl(input logic signed [15:0] v);
`ifdef FFT_SCALE_EN
    return v >>> 1;
`else
    return v;
`endif
  endfunction

  // Buffer (1-cycle read), twiddle ROM (1-cycle read), butterfly with BF_LATENCY-1 register stages.
  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= ld_r[i];
        mem_c[i] <= ld_c[i];
      end
    end else if (bus.o_wr_en) begin
      mem_r[bus.o_wr_addr_a] <= bus.o_wr_data_ra;
      mem_c[bus.o_wr_addr_a] <= bus.o_wr_data_ca;
      mem_r[bus.o_wr_addr_b] <= bus.o_wr_data_rb;
      mem_c[bus.o_wr_addr_b] <= bus.o_wr_data_cb;
    end
    if (bus.o_wr_en) begin
      if (wr_cnt < LOGSZ) wlog[wr_cnt] <= int'({bus.o_wr_addr_a, bus.o_wr_addr_b});
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.o_rd_en) begin
      bus.i_rd_data_ra <= mem_r[bus.o_rd_addr_a];
      bus.i_rd_data_ca <= mem_c[bus.o_rd_addr_a];
      bus.i_rd_data_rb <= mem_r[bus.o_rd_addr_b];
      bus.i_rd_data_cb <= mem_c[bus.o_rd_addr_b];
      if (rd_cnt < LOGSZ) rlog[rd_cnt] <= int'({bus.o_rd_addr_a, bus.o_rd_addr_b, 1'b0, bus.o_tw_addr});
      rd_cnt <= rd_cnt + 1;
    end
    bus.i_tw_r <= rom_r[bus.o_tw_addr];
    bus.i_tw_c <= rom_c[bus.o_tw_addr];
    p1 <= bfly(bus.o_bf_ra, bus.o_bf_ca, bus.o_bf_rb, bus.o_bf_cb, bus.o_bf_tw_r, bus.o_bf_tw_c);
    p2 <= p1;
  end

  assign bus.i_bf_ra = p2.ra;
  assign bus.i_bf_ca = p2.ca;
  assign bus.i_bf_rb = p2.rb;
  assign bus.i_bf_cb = p2.cb;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic logic any_out();
    return o_busy | o_done | bus.o_rd_en | bus.o_wr_en | (|bus.o_rd_addr_a) | (|bus.o_rd_addr_b)
         | (|bus.o_tw_addr) | (|bus.o_wr_addr_a) | (|bus.o_wr_addr_b)
         | (|bus.o_bf_ra) | (|bus.o_bf_ca) | (|bus.o_bf_rb) | (|bus.o_bf_cb)
         | (|bus.o_bf_tw_r) | (|bus.o_bf_tw_c)
         | (|bus.o_wr_data_ra) | (|bus.o_wr_data_ca) | (|bus.o_wr_data_rb) | (|bus.o_wr_data_cb);
  endfunction

  // Classic DIT in-place loops (span doubling, group outer, offset inner) on the model buffer.
  task automatic model_fft();
    bf_t r;
    for (int s = 0; s < LOG2N; s++) begin
      int span = 1 << s;
      for (int g = 0; g < N; g += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int a = g + j;
          int b = a + span;
          int t = j * (N / (2 * span));
          r = bfly(m_r[a], m_c[a], m_r[b], m_c[b], rom_r[t], rom_c[t]);
          m_r[a] = scl(r.ra);
          m_c[a] = scl(r.ca);
          m_r[b] = scl(r.rb);
          m_c[b] = scl(r.cb);
        end
      end
    end
  endtask

  // Natural-order x_r/x_c go into the buffer bit-reversed; the model starts from the same image.
  task automatic load_x();
    for (int i = 0; i < N; i++) begin
      ld_r[bit_reverse(i, LOG2N)] = x_r[i];
      ld_c[bit_reverse(i, LOG2N)] = x_c[i];
    end
    m_r = ld_r;
    m_c = ld_c;
    @(negedge clk);
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
    model_fft();
  endtask

  task automatic run_fft(input int restart_at, output int done_at, output int n_done,
                         output int busy_n, output int busy_first, output int busy_last);
    done_at = -1; n_done = 0; busy_n = 0; busy_first = -1; busy_last = -1;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 1; c <= RUN_CYC; c++) begin
      if (o_done) begin
        if (done_at < 0) done_at = c;
        n_done++;
      end
      if (o_busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        busy_n++;
      end
      i_start = (c == restart_at);
      @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  task automatic chk_timing(input string tag, input int done_at, input int n_done,
                            input int busy_n, input int busy_first, input int busy_last);
    chk({tag, "_done_cycle"}, done_at, DONE_CYC);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_busy_first"}, busy_first, 1);
    chk({tag, "_busy_last"}, busy_last, DONE_CYC);
    chk({tag, "_busy_len"}, busy_n, DONE_CYC);
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < N; i++)
      chk(tag, {mem_r[i], mem_c[i]}, {m_r[i], m_c[i]});
  endtask

  initial begin
    walk_t tbl[18];
    int done_at, n_done, busy_n, bfirst, blast, wb, rb, idle_busy;
    longint act, exp;

    for (int k = 0; k < N / 2; k++) begin
      tbl[k]     = '{k, 2 * k, 2 * k + 1, 0};
      tbl[8 + k] = '{24 + k, k, k + 8, k};
    end
    tbl[16] = '{9, 1, 3, 4};
    tbl[17] = '{21, 9, 13, 2};

    for (int j = 0; j < N / 2; j++) begin
      rom_r[j] = 16'(int'(32767.0 * $cos(2.0 * 3.14159265358979 * j / N)));
      rom_c[j] = 16'(int'(-32767.0 * $sin(2.0 * 3.14159265358979 * j / N)));
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs", any_out(), 0);
    rst_n = 1'b1;

    // Impulse: flat spectrum, plus address walk and full timing.
    for (int i = 0; i < N; i++) begin x_r[i] = 16'h0; x_c[i] = 16'h0; end
    x_r[0] = 16'h4000;
    load_x();
    wb = wr_cnt;
    rb = rd_cnt;
    run_fft(0, done_at, n_done, busy_n, bfirst, blast);
    chk_timing("impulse", done_at, n_done, busy_n, bfirst, blast);
    chk("wr_pulses", wr_cnt - wb, N_BF);
    foreach (tbl[e]) begin
      act = (longint'(wlog[wb + tbl[e].idx]) << 12) | longint'(rlog[rb + tbl[e].idx]);
      exp = (longint'(tbl[e].a) << 16) | (longint'(tbl[e].b) << 12) | (longint'(tbl[e].a) << 8)
          | (longint'(tbl[e].b) << 4) | longint'(tbl[e].tw);
      chk("addr_walk", act, exp);
    end
    for (int i = 0; i < N; i++) chk("impulse_bin", {mem_r[i], mem_c[i]}, {IMP_BIN, 16'h0});
    chk_model("impulse_model");

    // DC input with a start pulse mid-run that must be ignored.
    for (int i = 0; i < N; i++) begin x_r[i] = DC_AMP; x_c[i] = 16'h0; end
    load_x();
    run_fft(50, done_at, n_done, busy_n, bfirst, blast);
    chk_timing("start_busy", done_at, n_done, busy_n, bfirst, blast);
    chk("dc_bin0", {mem_r[0], mem_c[0]}, {DC_BIN0, 16'h0});
    for (int i = 1; i < N; i++) begin
      chk_tol("dc_bin_re", int'(mem_r[i]), 0, 2);
      chk_tol("dc_bin_im", int'(mem_c[i]), 0, 2);
    end
    chk_model("dc_model");

    // Random complex inputs against the reference model.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        x_r[i] = 16'(int'($urandom_range(0, 2046)) - 1023);
        x_c[i] = 16'(int'($urandom_range(0, 2046)) - 1023);
      end
      load_x();
      run_fft(0, done_at, n_done, busy_n, bfirst, blast);
      chk("rand_done_cycle", done_at, DONE_CYC);
      chk_model("rand_model");
    end

    // Reset at cycle 100 aborts; the partially transformed buffer is then transformed again.
    for (int i = 0; i < N; i++) begin
      x_r[i] = 16'(int'($urandom_range(0, 2046)) - 1023);
      x_c[i] = 16'(int'($urandom_range(0, 2046)) - 1023);
    end
    load_x();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", any_out(), 0);
    rst_n = 1'b1;
    idle_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_busy || o_done || bus.o_rd_en || bus.o_wr_en) idle_busy++;
    end
    chk("post_reset_idle", idle_busy, 0);
    m_r = mem_r;
    m_c = mem_c;
    model_fft();
    run_fft(0, done_at, n_done, busy_n, bfirst, blast);
    chk_timing("after_reset", done_at, n_done, busy_n, bfirst, blast);
    chk_model("after_reset_model");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
